// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and defaults for the instruction fetch stage
package ifetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            fault;
    logic            misalign;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] next_word_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/ifetch_fetch_fifo.sv
// rtl/ifetch_fetch_fifo.sv - in-order entry buffer with registered head and synchronous clear
module fetch_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  input  logic                   clear,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int CW = $clog2(DEPTH) + 1;

  entry_t        slots [DEPTH];
  logic          do_push;
  logic          do_pop;
  logic [CW-1:0] wr_idx;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Slot 0 is always the head, so a pop shifts and a simultaneous push lands one lower.
  assign wr_idx  = count - CW'(do_pop);
  assign head    = slots[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      if (do_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) slots[i] <= slots[i+1];
      end
      if (do_push) slots[wr_idx[CW-2:0]] <= push_data;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch: PC sequencing, credit-limited memory requests, redirect flush
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_v_o,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_req_ready_i,
  input  logic            imem_rsp_v_i,
  input  logic [31:0]     imem_rsp_data_i,
  input  logic            imem_rsp_err_i,
  input  logic            redirect_v_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_v_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            fetch_fault_o,
  output logic            fetch_misalign_o,
  input  logic            dec_ready_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] resp_pc_q;
  logic [CW-1:0]   outstanding_q;
  logic [CW-1:0]   drop_cnt_q;
  logic [CW-1:0]   fifo_count;
  logic            halted_q;
  logic            misalign_pend_q;
  logic            fifo_full;
  logic            fifo_empty;
  logic            credit_ok;
  logic            req_fire;
  logic            rsp_keep;
  logic            push_en;
  logic            pop_en;
  logic            redirect_misaligned;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Outstanding requests and buffered entries share one credit pool, so the buffer never overflows.
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
  assign imem_req_v_o    = reset_n & ~halted_q & ~redirect_v_i & credit_ok;
  assign imem_req_addr_o = pc_q;
  assign req_fire        = imem_req_v_o & imem_req_ready_i;

  assign redirect_misaligned = (redirect_pc_i[1:0] != 2'b00);
  assign rsp_keep = imem_rsp_v_i & (drop_cnt_q == '0) & ~redirect_v_i;
  assign push_en  = ~redirect_v_i & (rsp_keep | misalign_pend_q);
  assign pop_en   = instr_v_o & dec_ready_i;

  always_comb begin
    push_entry = '0;
    push_entry.pc = resp_pc_q;
    if (misalign_pend_q) begin
      push_entry.misalign = 1'b1;
    end else begin
      push_entry.instr = imem_rsp_data_i;
      push_entry.fault = imem_rsp_err_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q            <= RESET_PC;
      resp_pc_q       <= RESET_PC;
      outstanding_q   <= '0;
      drop_cnt_q      <= '0;
      halted_q        <= 1'b0;
      misalign_pend_q <= 1'b0;
    end else if (redirect_v_i) begin
      // Every request still in flight becomes stale, including one answering right now.
      pc_q            <= redirect_pc_i;
      resp_pc_q       <= redirect_pc_i;
      outstanding_q   <= outstanding_q - CW'(imem_rsp_v_i);
      drop_cnt_q      <= outstanding_q - CW'(imem_rsp_v_i);
      halted_q        <= redirect_misaligned;
      misalign_pend_q <= redirect_misaligned;
    end else begin
      if (req_fire) pc_q <= next_word_pc(pc_q);
      outstanding_q <= outstanding_q + CW'(req_fire) - CW'(imem_rsp_v_i);
      if (imem_rsp_v_i && drop_cnt_q != '0) drop_cnt_q <= drop_cnt_q - CW'(1);
      if (rsp_keep) begin
        resp_pc_q <= next_word_pc(resp_pc_q);
        if (imem_rsp_err_i) halted_q <= 1'b1;
      end
      misalign_pend_q <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_en),
    .push_data (push_entry),
    .pop       (pop_en),
    .clear     (redirect_v_i),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign instr_v_o        = ~fifo_empty;
  assign instr_o          = head.instr;
  assign pc_o             = head.pc;
  assign fetch_fault_o    = head.fault & ~fifo_empty;
  assign fetch_misalign_o = head.misalign & ~fifo_empty;

  a_no_rsp_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    imem_rsp_v_i |-> outstanding_q != '0);
  a_drop_bounded: assert property (@(posedge clk) disable iff (!reset_n)
    drop_cnt_q <= outstanding_q);
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    (push_en && fifo_full && !redirect_v_i) |-> pop_en);

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - randomized and directed bench for ifetch against a queue-based fetch model
module tb_ifetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req_v_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i = 1'b0;
  logic        imem_rsp_v_i = 1'b0;
  logic [31:0] imem_rsp_data_i = 32'h0;
  logic        imem_rsp_err_i = 1'b0;
  logic        redirect_v_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        instr_v_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        fetch_fault_o;
  logic        fetch_misalign_o;
  logic        dec_ready_i = 1'b0;

  always #5 clk = ~clk;

  ifetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .imem_req_v_o     (imem_req_v_o),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_rsp_v_i     (imem_rsp_v_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .imem_rsp_err_i   (imem_rsp_err_i),
    .redirect_v_i     (redirect_v_i),
    .redirect_pc_i    (redirect_pc_i),
    .instr_v_o        (instr_v_o),
    .instr_o          (instr_o),
    .pc_o             (pc_o),
    .fetch_fault_o    (fetch_fault_o),
    .fetch_misalign_o (fetch_misalign_o),
    .dec_ready_i      (dec_ready_i)
  );

  typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; bit fault; bit mis; } ent_t;

  mreq_t       memq[$];
  ent_t        fifo_m[$];
  ent_t        popq[$];
  logic [31:0] acc_log[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          halted_m, mis_pend;
  logic [31:0] exp_req_addr, exp_rsp_pc, mis_pc;
  int          rdy_pct = 100, dec_pct = 100, lat_min = 1, lat_max = 1;
  bit          fault_on = 0;
  logic [31:0] fault_addr = 32'h0;
  int          first_acc_cyc = -1, first_iv_cyc = -1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit is_fault(input logic [31:0] a);
    return fault_on && (a == fault_addr);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    popq.delete();
    acc_log.delete();
    first_acc_cyc = -1;
    first_iv_cyc = -1;
  endtask

  // One clock cycle: drive at negedge, compare 1ns later, advance the model at posedge.
  task automatic step(input bit redir, input logic [31:0] rpc);
    bit rsp, pop, acc;
    logic [31:0] raddr;
    imem_req_ready_i = ($urandom_range(1, 100) <= rdy_pct);
    dec_ready_i      = ($urandom_range(1, 100) <= dec_pct);
    redirect_v_i     = redir;
    redirect_pc_i    = rpc;
    rsp   = (memq.size() > 0) && (memq[0].due <= cyc);
    raddr = rsp ? memq[0].addr : 32'h0;
    imem_rsp_v_i    = rsp;
    imem_rsp_data_i = rsp ? mem_word(raddr) : 32'h0;
    imem_rsp_err_i  = rsp && is_fault(raddr);
    #1;
    chk("req_v", imem_req_v_o, !halted_m && !redir && (memq.size() + fifo_m.size() < DEPTH));
    if (imem_req_v_o) chk("req_addr", imem_req_addr_o, exp_req_addr);
    chk("instr_v", instr_v_o, fifo_m.size() > 0);
    if (instr_v_o && fifo_m.size() > 0) begin
      chk("pc_o", pc_o, fifo_m[0].pc);
      chk("instr_o", instr_o, fifo_m[0].instr);
      chk("fault", fetch_fault_o, fifo_m[0].fault);
      chk("misalign", fetch_misalign_o, fifo_m[0].mis);
    end
    acc = imem_req_v_o && imem_req_ready_i;
    pop = !redir && dec_ready_i && (fifo_m.size() > 0);
    if (acc) begin
      acc_log.push_back(imem_req_addr_o);
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
    end
    if (instr_v_o && first_iv_cyc < 0) first_iv_cyc = cyc;
    if (!redir && instr_v_o && dec_ready_i)
      popq.push_back('{pc_o, instr_o, fetch_fault_o, fetch_misalign_o});
    @(posedge clk);
    if (redir) begin
      fifo_m.delete();
      foreach (memq[i]) memq[i].stale = 1'b1;
      halted_m = (rpc[1:0] != 2'b00);
      mis_pend = halted_m;
      mis_pc = rpc;
      exp_req_addr = rpc;
      exp_rsp_pc = rpc;
      if (rsp) void'(memq.pop_front());
    end else begin
      if (pop) void'(fifo_m.pop_front());
      if (rsp) begin
        if (!memq[0].stale) begin
          fifo_m.push_back('{exp_rsp_pc, mem_word(exp_rsp_pc), is_fault(exp_rsp_pc), 1'b0});
          if (is_fault(exp_rsp_pc)) halted_m = 1'b1;
          exp_rsp_pc = exp_rsp_pc + 32'd4;
        end
        void'(memq.pop_front());
      end
      if (mis_pend) begin
        fifo_m.push_back('{mis_pc, 32'h0, 1'b0, 1'b1});
        mis_pend = 1'b0;
      end
    end
    if (acc) begin
      memq.push_back('{imem_req_addr_o, cyc + int'($urandom_range(lat_min, lat_max)), 1'b0});
      if (!redir) exp_req_addr = exp_req_addr + 32'd4;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    imem_req_ready_i = 1'b0;
    imem_rsp_v_i = 1'b0;
    imem_rsp_err_i = 1'b0;
    redirect_v_i = 1'b0;
    dec_ready_i = 1'b0;
    memq.delete();
    fifo_m.delete();
    halted_m = 1'b0;
    mis_pend = 1'b0;
    exp_req_addr = RST_PC;
    exp_rsp_pc = RST_PC;
    #1;
    chk("rst_req_v", imem_req_v_o, 1'b0);
    chk("rst_req_addr", imem_req_addr_o, RST_PC);
    chk("rst_instr_v", instr_v_o, 1'b0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_fault", fetch_fault_o, 1'b0);
    chk("rst_misalign", fetch_misalign_o, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] tgt;
    @(negedge clk);
    apply_reset();

    // Streaming at full rate from the reset PC
    clear_logs();
    repeat (12) step(1'b0, 32'h0);
    chk("t1_acc_cnt", acc_log.size(), 12);
    for (int k = 0; k < 4; k++) if (k < acc_log.size()) chk("t1_acc_addr", acc_log[k], 32'(4 * k));
    chk("t1_first_latency", first_iv_cyc - first_acc_cyc, 2);
    chk("t1_pop_cnt", popq.size(), 10);
    for (int k = 0; k < popq.size(); k++) chk("t1_pop_pc", popq[k].pc, 32'(4 * k));

    // Decode stall fills the buffer, then drains without loss
    dec_pct = 0;
    step(1'b1, 32'h200);
    clear_logs();
    repeat (10) step(1'b0, 32'h0);
    chk("t2_acc_cnt", acc_log.size(), 4);
    chk("t2_req_v_low", imem_req_v_o, 1'b0);
    dec_pct = 100;
    repeat (12) step(1'b0, 32'h0);
    chk("t2_pop_some", popq.size() >= 8, 1'b1);
    for (int k = 0; k < popq.size(); k++) chk("t2_pop_pc", popq[k].pc, 32'h200 + 32'(4 * k));

    // Three requests in flight on a slow memory, then redirect
    lat_min = 3; lat_max = 3;
    step(1'b1, 32'h1000);
    for (int k = 0; k < 10 && memq.size() < 3; k++) step(1'b0, 32'h0);
    chk("t3_inflight", memq.size(), 3);
    step(1'b1, 32'h100);
    clear_logs();
    repeat (15) step(1'b0, 32'h0);
    chk("t3_pops", popq.size() > 0, 1'b1);
    if (popq.size() > 0) chk("t3_first_pc", popq[0].pc, 32'h100);

    // Access fault at 0x8 halts fetch until redirect
    lat_min = 1; lat_max = 1;
    fault_on = 1'b1; fault_addr = 32'h8;
    step(1'b1, 32'h0);
    clear_logs();
    repeat (12) step(1'b0, 32'h0);
    chk("t4_acc_cnt", acc_log.size(), 4);
    chk("t4_pop_cnt", popq.size(), 4);
    if (popq.size() > 3) begin
      chk("t4_fault_pc", popq[2].pc, 32'h8);
      chk("t4_fault_flag", popq[2].fault, 1'b1);
      chk("t4_after_fault", popq[3].fault, 1'b0);
    end
    step(1'b1, 32'h40);
    clear_logs();
    repeat (6) step(1'b0, 32'h0);
    chk("t4_resume", acc_log.size() > 0 ? acc_log[0] : 32'hDEAD_BEEF, 32'h40);
    fault_on = 1'b0;

    // Misaligned redirect produces one exception entry and no requests
    step(1'b1, 32'h102);
    clear_logs();
    repeat (8) step(1'b0, 32'h0);
    chk("t5_no_req", acc_log.size(), 0);
    chk("t5_pop_cnt", popq.size(), 1);
    if (popq.size() > 0) begin
      chk("t5_pc", popq[0].pc, 32'h102);
      chk("t5_misalign", popq[0].mis, 1'b1);
      chk("t5_instr", popq[0].instr, 32'h0);
    end

    // PC wraps around the top of the address space
    step(1'b1, 32'hFFFF_FFF8);
    clear_logs();
    repeat (6) step(1'b0, 32'h0);
    chk("t6_acc_cnt", acc_log.size() >= 3, 1'b1);
    if (acc_log.size() >= 3) begin
      chk("t6_wrap0", acc_log[0], 32'hFFFF_FFF8);
      chk("t6_wrap1", acc_log[1], 32'hFFFF_FFFC);
      chk("t6_wrap2", acc_log[2], 32'h0000_0000);
    end

    // Redirect in the same cycle as a response
    lat_min = 2; lat_max = 2;
    step(1'b1, 32'h500);
    repeat (4) step(1'b0, 32'h0);
    for (int k = 0; k < 10 && !(memq.size() > 0 && memq[0].due <= cyc); k++) step(1'b0, 32'h0);
    chk("t7_rsp_coincident", memq.size() > 0 && memq[0].due <= cyc, 1'b1);
    step(1'b1, 32'h300);
    clear_logs();
    repeat (10) step(1'b0, 32'h0);
    chk("t7_pops", popq.size() > 0, 1'b1);
    if (popq.size() > 0) chk("t7_first_pc", popq[0].pc, 32'h300);

    // Reset in the middle of a stream with two requests outstanding
    lat_min = 3; lat_max = 3;
    step(1'b1, 32'h600);
    repeat (2) step(1'b0, 32'h0);
    chk("t8_inflight", memq.size(), 2);
    apply_reset();
    lat_min = 1; lat_max = 1;
    clear_logs();
    repeat (8) step(1'b0, 32'h0);
    chk("t8_restart_addr", acc_log.size() > 0 ? acc_log[0] : 32'hDEAD_BEEF, RST_PC);
    chk("t8_restart_pop", popq.size() > 0 ? popq[0].pc : 32'hDEAD_BEEF, RST_PC);

    // Randomized traffic with redirects, faults and misaligned targets
    rdy_pct = 70; dec_pct = 60; lat_min = 1; lat_max = 4;
    fault_on = 1'b1; fault_addr = 32'hFFFF_FFF0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        tgt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'b10;
        if ($urandom_range(0, 1) == 0)
          fault_addr = {tgt[31:2], 2'b00} + 32'(4 * $urandom_range(0, 12));
        else
          fault_addr = 32'hFFFF_FFF0;
        step(1'b1, tgt);
      end else begin
        step(1'b0, 32'h0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end

endmodule
